// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet receive FCS path.
// CRC-32 constants, FSM state type and frame status bit positions.
package eth_pkg;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam logic [10:0] FCS_BYTES = 11'd4;
  localparam logic [10:0] CNT_MAX   = 11'h7FF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_PASS
  } state_t;

  localparam int BAD_CRC = 0;
  localparam int BAD_LEN = 1;
  localparam int BAD_PHY = 2;

endpackage

// File: rtl/eth_rx_fcs_check_if.sv
// Byte stream bundle: data, valid, last and a per-byte user flag.
// On the receive side user carries PHY rx_er; on the output it marks a bad frame.
interface eth_rx_fcs_check_if;

  logic [7:0] data;
  logic       valid;
  logic       last;
  logic       user;

  modport master (
    output data,
    output valid,
    output last,
    output user
  );

  modport slave (
    input data,
    input valid,
    input last,
    input user
  );

endinterface

// File: rtl/eth_crc32_byte.sv
// Combinational CRC-32 update for one byte, LSB first, reflected form.
// Shared between the receive checker and the transmit FCS generator.
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  // Eight serial shift steps unrolled into one combinational stage
  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// Receive FCS, length and PHY-error checker with registered byte output.
// Define ETH_RX_FCS_STRIP_EN to remove the 4 FCS bytes from the output.
module eth_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int P_MIN_LEN = 64,
  parameter int P_MAX_LEN = 1518
) (
  input  logic                      rx_clk,
  input  logic                      rst,
  eth_rx_fcs_check_if.slave         s,
  eth_rx_fcs_check_if.master        m,
  output logic                      frame_good,
  output logic [2:0]                frame_bad
);

  localparam logic [10:0] MIN_L = 11'(P_MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(P_MAX_LEN);

  state_t      state, state_nx;
  logic [31:0] crc_q, crc_base, crc_nx;
  logic [10:0] cnt_q, cnt_base, cnt_nx;
  logic        phy_q, phy_base, phy_nx;
  logic [2:0]  bad_nx;
  logic        acc, fin, emit;
  logic [7:0]  out_byte;

  eth_crc32_byte u_crc (
    .crc_in  (crc_base),
    .data    (s.data),
    .crc_out (crc_nx)
  );

  // A byte seen in IDLE starts a fresh frame, so it sees reset accumulators
  always_comb begin
    state_nx = state;
    acc      = s.valid;
    fin      = s.valid & s.last;
    crc_base = (state == ST_IDLE) ? CRC_INIT : crc_q;
    cnt_base = (state == ST_IDLE) ? 11'd0 : cnt_q;
    phy_base = (state == ST_IDLE) ? 1'b0 : phy_q;
    cnt_nx   = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + 11'd1;
    phy_nx   = phy_base | s.user;
    bad_nx          = 3'b000;
    bad_nx[BAD_CRC] = (crc_nx != CRC_RESIDUE);
    bad_nx[BAD_LEN] = (cnt_nx < MIN_L) || (cnt_nx > MAX_L);
    bad_nx[BAD_PHY] = phy_nx;
    unique case (state)
      ST_IDLE: if (acc) state_nx = ST_FILL;
      ST_FILL: if (acc && cnt_nx == FCS_BYTES) state_nx = ST_PASS;
      ST_PASS: state_nx = ST_PASS;
      default: state_nx = ST_IDLE;
    endcase
    if (fin) state_nx = ST_IDLE;
`ifdef ETH_RX_FCS_STRIP_EN
    emit = acc && (state == ST_PASS);
`else
    emit = acc;
`endif
  end

  // FSM state register
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Per-frame CRC, length and sticky PHY error accumulators
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      crc_q <= CRC_INIT;
      cnt_q <= 11'd0;
      phy_q <= 1'b0;
    end else if (acc) begin
      crc_q <= crc_nx;
      cnt_q <= cnt_nx;
      phy_q <= phy_nx;
    end
  end

`ifdef ETH_RX_FCS_STRIP_EN
  logic [7:0] dly_q [4];

  assign out_byte = dly_q[0];

  // Four-byte delay so the trailing FCS is never emitted
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) dly_q[i] <= 8'h00;
    end else if (acc) begin
      for (int i = 0; i < 3; i++) dly_q[i] <= dly_q[i+1];
      dly_q[3] <= s.data;
    end
  end
`else
  assign out_byte = s.data;
`endif

  // Registered output byte stream and end-of-frame status
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      m.data     <= 8'h00;
      m.valid    <= 1'b0;
      m.last     <= 1'b0;
      m.user     <= 1'b0;
      frame_good <= 1'b0;
      frame_bad  <= 3'b000;
    end else begin
      m.data     <= emit ? out_byte : m.data;
      m.valid    <= emit;
      m.last     <= emit & fin;
      m.user     <= emit & fin & (|bad_nx);
      frame_good <= fin & ~(|bad_nx);
      frame_bad  <= fin ? bad_nx : 3'b000;
    end
  end

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Randomized self-checking bench for eth_rx_fcs_check.
// Reference model works on whole frames held in queues.
module tb_eth_rx_fcs_check;

  localparam int MIN_L = 64;
  localparam int MAX_L = 1518;

  logic       rx_clk = 1'b0;
  logic       rst;
  logic       frame_good;
  logic [2:0] frame_bad;

  always #5 rx_clk = ~rx_clk;

  eth_rx_fcs_check_if s_if ();
  eth_rx_fcs_check_if m_if ();

  eth_rx_fcs_check #(
    .P_MIN_LEN (MIN_L),
    .P_MAX_LEN (MAX_L)
  ) dut (
    .rx_clk     (rx_clk),
    .rst        (rst),
    .s          (s_if),
    .m          (m_if),
    .frame_good (frame_good),
    .frame_bad  (frame_bad)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
  } ob_t;

  ob_t        ob_q [$];
  logic [2:0] st_q [$];
  int         n_chk  = 0;
  int         n_fail = 0;
  bit         ignore = 1'b0;
  logic       st_due;
  logic       acc_prev;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fcs_of(input logic [7:0] b [$],
                                         input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic make_frame(input int n, output logic [7:0] q [$]);
    logic [31:0] f;
    q = {};
    if (n >= 4) begin
      for (int i = 0; i < n - 4; i++) q.push_back(8'($urandom));
      f = fcs_of(q, n - 4);
      q.push_back(f[7:0]);
      q.push_back(f[15:8]);
      q.push_back(f[23:16]);
      q.push_back(f[31:24]);
    end else begin
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    end
  endtask

  task automatic idle(input int n);
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    s_if.user  = 1'b0;
    repeat (n) @(negedge rx_clk);
  endtask

  // gap: 0 contiguous, 1 every other cycle, 2 random
  task automatic send_frame(input logic [7:0] q [$], input int gap,
                            input int err_idx);
    int         n;
    int         g;
    bit         fcs_ok;
    logic [2:0] bad;
    ob_t        e;
    n      = q.size();
    fcs_ok = (n >= 4) &&
             ({q[n-1], q[n-2], q[n-3], q[n-4]} == fcs_of(q, n - 4));
    bad    = {err_idx >= 0 && err_idx < n,
              n < MIN_L || n > MAX_L,
              !fcs_ok};
    st_q.push_back(bad);
`ifdef ETH_RX_FCS_STRIP_EN
    for (int i = 0; i < n - 4; i++) begin
      e.d = q[i]; e.l = (i == n - 5); e.u = |bad;
      ob_q.push_back(e);
    end
`else
    for (int i = 0; i < n; i++) begin
      e.d = q[i]; e.l = (i == n - 1); e.u = |bad;
      ob_q.push_back(e);
    end
`endif
    for (int i = 0; i < n; i++) begin
      g = (gap == 0) ? 0 : (gap == 1) ? 1 : int'($urandom_range(0, 2));
      if (g > 0) idle(g);
      s_if.valid = 1'b1;
      s_if.data  = q[i];
      s_if.last  = (i == n - 1);
      s_if.user  = (i == err_idx);
      @(negedge rx_clk);
    end
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    s_if.user  = 1'b0;
  endtask

  // Start a frame, abort it with reset after nbytes, expect nothing from it
  task automatic abort_frame(input int nbytes);
    logic [7:0] q [$];
    make_frame(64, q);
    ignore = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      s_if.valid = 1'b1;
      s_if.data  = q[i];
      s_if.last  = 1'b0;
      s_if.user  = 1'b0;
      @(negedge rx_clk);
    end
    idle(1);
    rst = 1'b1;
    #1;
    chk("abort_m_valid", 32'(m_if.valid), 0);
    chk("abort_status", {28'h0, frame_good, frame_bad}, 0);
    @(negedge rx_clk);
    @(negedge rx_clk);
    rst    = 1'b0;
    ignore = 1'b0;
  endtask

  always @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      st_due   <= 1'b0;
      acc_prev <= 1'b0;
    end else begin
      st_due   <= s_if.valid & s_if.last;
      acc_prev <= s_if.valid;
    end
  end

  always @(negedge rx_clk) begin
    ob_t        e;
    logic [2:0] eb;
    logic       stat;
    if (!rst) begin
      if (m_if.valid) chk("m_valid_cause", 32'(acc_prev), 1);
      if (m_if.valid && !ignore) begin
        if (ob_q.size() == 0) begin
          chk("m_unexpected", 1, 0);
        end else begin
          e = ob_q.pop_front();
          chk("m_data", 32'(m_if.data), 32'(e.d));
          chk("m_last", 32'(m_if.last), 32'(e.l));
          if (e.l) chk("m_user", 32'(m_if.user), 32'(e.u));
        end
      end
      stat = frame_good || (frame_bad != 3'b000);
      if (stat || st_due) chk("status_timing", 32'(stat), 32'(st_due));
      if (stat) begin
        if (st_q.size() == 0) begin
          chk("status_unexpected", 1, 0);
        end else begin
          eb = st_q.pop_front();
          chk("frame_bad", 32'(frame_bad), 32'(eb));
          chk("frame_good", 32'(frame_good), 32'(eb == 3'b000));
          if (m_if.valid && m_if.last)
            chk("m_user_vs_bad", 32'(m_if.user), 32'(|frame_bad));
        end
      end
    end
  end

  initial begin
    logic [7:0] q [$];
    logic [7:0] p [$];
    int         n;
    int         pick;
    rst        = 1'b1;
    s_if.valid = 1'b0;
    s_if.data  = 8'h00;
    s_if.last  = 1'b0;
    s_if.user  = 1'b0;
    repeat (3) @(negedge rx_clk);
    chk("rst_m_valid", 32'(m_if.valid), 0);
    chk("rst_m_last", 32'(m_if.last), 0);
    chk("rst_m_user", 32'(m_if.user), 0);
    chk("rst_m_data", 32'(m_if.data), 0);
    chk("rst_frame_good", 32'(frame_good), 0);
    chk("rst_frame_bad", 32'(frame_bad), 0);
    rst = 1'b0;
    idle(2);

    make_frame(64, q);
    send_frame(q, 0, -1);
    idle(3);

    p = q;
    p[20] = p[20] ^ 8'h08;
    send_frame(p, 0, -1);
    idle(3);

    q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
         8'h26, 8'h39, 8'hF4, 8'hCB};
    send_frame(q, 0, -1);
    idle(3);

    make_frame(3, q);
    send_frame(q, 0, -1);
    make_frame(64, q);
    send_frame(q, 0, -1);
    idle(3);

    make_frame(64, q);
    send_frame(q, 1, 30);
    idle(3);

    abort_frame(40);
    make_frame(64, q);
    send_frame(q, 0, -1);
    idle(3);

    foreach (q[i]) q[i] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      n = (k == 0) ? 63 : (k == 1) ? 64 : (k == 2) ? 1518 : 1519;
      make_frame(n, q);
      send_frame(q, 0, -1);
      idle(2);
    end

    for (int k = 0; k < 30; k++) begin
      pick = int'($urandom_range(0, 2));
      n = (pick == 0) ? int'($urandom_range(1, 8)) :
          (pick == 1) ? int'($urandom_range(60, 70)) :
                        int'($urandom_range(20, 200));
      make_frame(n, q);
      if ($urandom_range(0, 3) == 0 && n > 0)
        q[$urandom_range(0, n - 1)] ^= 8'(1 << $urandom_range(0, 7));
      send_frame(q, int'($urandom_range(0, 2)),
                 ($urandom_range(0, 3) == 0) ?
                   int'($urandom_range(0, n - 1)) : -1);
      idle(int'($urandom_range(0, 3)));
    end

    idle(10);
    chk("out_queue_drained", ob_q.size(), 0);
    chk("status_queue_drained", st_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
